// File: rtl/pe_array_ctrl.sv
// Window sequencer for pe_array: buffers one window from a valid/ready stream, then clears, replays and captures.
// Optional PE_ARRAY_CTRL_PERF_CNT_EN adds a saturating LOAD stall counter on oPerfStallCycles.
module pe_array_ctrl #(
    parameter int ARRAY_NUM   = 3,
    parameter int KERNEL_SIZE = 3,
    parameter int PE_LATENCY  = 2
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iStart,
    input  logic [4:0]             iCfsOutputLeftShift,
    input  logic                   iInValid,
    output logic                   oInReady,
    input  logic [8*ARRAY_NUM-1:0] iInData,
    input  logic [7:0]             iInWeight,
    output logic                   oClearAcc,
    output logic [ARRAY_NUM-2:0]   oCfsPassDataLeft,
    output logic [8*ARRAY_NUM-1:0] oData,
    output logic [7:0]             oWeight,
    output logic [4:0]             oCfsOutputLeftShift,
    input  logic [8*ARRAY_NUM-1:0] iResult,
    output logic [8*ARRAY_NUM-1:0] oResult,
    output logic                   oResultValid,
    output logic                   oBusy
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]            oPerfStallCycles
`endif
);

    localparam int TAPS    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int STEPS   = TAPS + ARRAY_NUM - 1;
    localparam int CNT_MAX = (STEPS > PE_LATENCY) ? STEPS : PE_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(STEPS);
    localparam int WIW     = $clog2(TAPS);

    localparam logic [CW-1:0] LAST_BEAT  = CW'(STEPS - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(PE_LATENCY - 1);
    localparam logic [CW-1:0] TAPS_C     = CW'(TAPS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]             state;
    logic [2:0]             next_state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          next_cnt;
    logic [ARRAY_NUM-2:0]   pass_next;
    int                     tap;

    logic [8*ARRAY_NUM-1:0] data_buf   [STEPS];
    logic [7:0]             weight_buf [TAPS];

    assign oInReady = (state == S_LOAD);
    assign oBusy    = (state != S_IDLE);

    // One shared counter indexes LOAD beats, RUN beats and DRAIN wait cycles.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            S_IDLE: begin
                if (iStart) begin
                    next_state = S_LOAD;
                    next_cnt   = '0;
                end
            end
            S_LOAD: begin
                if (iInValid) begin
                    if (cnt == LAST_BEAT) begin
                        next_state = S_CLEAR;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                next_state = S_RUN;
                next_cnt   = '0;
            end
            S_RUN: begin
                if (cnt == LAST_BEAT) begin
                    next_state = S_DRAIN;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    next_state = S_DONE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
            default: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // PE j sees tap u = s - j; it shifts left on every tap except the first of each kernel row.
    always_comb begin
        pass_next = '0;
        tap       = 0;
        for (int j = 0; j < ARRAY_NUM - 1; j++) begin
            tap = int'(next_cnt) - j;
            if (tap >= 0 && tap < TAPS && (tap % KERNEL_SIZE) != 0) begin
                pass_next[j] = 1'b1;
            end
        end
    end

    // Outputs are registered from the next-state values so beat s is on oData during RUN cycle s.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            oClearAcc           <= 1'b0;
            oCfsPassDataLeft    <= '0;
            oData               <= '0;
            oWeight             <= '0;
            oCfsOutputLeftShift <= '0;
            oResult             <= '0;
            oResultValid        <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            oClearAcc    <= (next_state == S_CLEAR);
            oResultValid <= (next_state == S_DONE);
            if (next_state == S_RUN) begin
                oData            <= data_buf[next_cnt[IW-1:0]];
                oWeight          <= (next_cnt < TAPS_C) ? weight_buf[next_cnt[WIW-1:0]] : 8'd0;
                oCfsPassDataLeft <= pass_next;
            end else begin
                oData            <= '0;
                oWeight          <= '0;
                oCfsPassDataLeft <= '0;
            end
            if (next_state == S_DONE) begin
                oResult <= iResult;
            end
            if (state == S_IDLE && iStart) begin
                oCfsOutputLeftShift <= iCfsOutputLeftShift;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (state == S_LOAD && iInValid) begin
            data_buf[cnt[IW-1:0]] <= iInData;
            if (cnt < TAPS_C) begin
                weight_buf[cnt[WIW-1:0]] <= iInWeight;
            end
        end
    end

`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && iStart) begin
            stall_cnt <= '0;
        end else if (state == S_LOAD && !iInValid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign oPerfStallCycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl (ARRAY_NUM=3, K=3, PE_LATENCY=2): nominal window table plus corner sequences.
module tb_pe_array_ctrl;

    localparam logic [23:0] RES_VAL = 24'hA5C3E7;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iStart;
    logic [4:0]  iCfsOutputLeftShift;
    logic        iInValid;
    logic        oInReady;
    logic [23:0] iInData;
    logic [7:0]  iInWeight;
    logic        oClearAcc;
    logic [1:0]  oCfsPassDataLeft;
    logic [23:0] oData;
    logic [7:0]  oWeight;
    logic [4:0]  oCfsOutputLeftShift;
    logic [23:0] iResult;
    logic [23:0] oResult;
    logic        oResultValid;
    logic        oBusy;
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
    logic [15:0] oPerfStallCycles;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pe_array_ctrl #(.ARRAY_NUM(3), .KERNEL_SIZE(3), .PE_LATENCY(2)) dut (
        .iClk                (iClk),
        .iRstN               (iRstN),
        .iStart              (iStart),
        .iCfsOutputLeftShift (iCfsOutputLeftShift),
        .iInValid            (iInValid),
        .oInReady            (oInReady),
        .iInData             (iInData),
        .iInWeight           (iInWeight),
        .oClearAcc           (oClearAcc),
        .oCfsPassDataLeft    (oCfsPassDataLeft),
        .oData               (oData),
        .oWeight             (oWeight),
        .oCfsOutputLeftShift (oCfsOutputLeftShift),
        .iResult             (iResult),
        .oResult             (oResult),
        .oResultValid        (oResultValid),
        .oBusy               (oBusy)
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
        ,
        .oPerfStallCycles    (oPerfStallCycles)
`endif
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [23:0] in_data;
        logic [7:0]  in_w;
        logic [37:0] exp_out;
    } vec_t;

    vec_t vecs [28];

    function automatic logic [23:0] beat_data(input int s);
        logic [7:0] b;
        b = 8'(s);
        return {8'h30 + b, 8'h20 + b, 8'h10 + b};
    endfunction

    function automatic logic [7:0] beat_w(input int s);
        return 8'h80 + 8'(s);
    endfunction

    // {ready, clear, pass[1:0], data, weight, result_valid, busy}
    function automatic logic [37:0] out_bundle();
        return {oInReady, oClearAcc, oCfsPassDataLeft, oData, oWeight, oResultValid, oBusy};
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        iStart    = v.start;
        iInValid  = v.valid;
        iInData   = v.in_data;
        iInWeight = v.in_w;
    endtask

    // Runs one window from a start at relative cycle 0, with optional bubble, stray start and reset injection.
    task automatic run_window(input logic [4:0] shift0, input logic [4:0] shift_later,
                              input int bub_start, input int bub_len,
                              input int start_inj, input int rst_inj,
                              output int clear_cyc, output int rv_cyc, output int rv_count);
        int b;
        b         = 0;
        clear_cyc = -1;
        rv_cyc    = -1;
        rv_count  = 0;
        for (int r = 0; r < 45; r++) begin
            if (rst_inj >= 0 && r == rst_inj + 1) begin
                check_output("reset_mid_outputs", 64'(out_bundle()), 64'd0);
                check_output("reset_mid_result", 64'(oResult), 64'd0);
                check_output("reset_mid_shift", 64'(oCfsOutputLeftShift), 64'd0);
            end
            iRstN               = (r == rst_inj) ? 1'b0 : 1'b1;
            iStart              = (r == 0) || (r == start_inj);
            iCfsOutputLeftShift = (r == 0) ? shift0 : shift_later;
            if (oInReady && !(r >= bub_start && r < bub_start + bub_len) && b < 11) begin
                iInValid  = 1'b1;
                iInData   = beat_data(b);
                iInWeight = beat_w(b);
                b++;
            end else begin
                iInValid  = 1'b0;
                iInData   = '0;
                iInWeight = '0;
            end
            if (oClearAcc && clear_cyc < 0) clear_cyc = r;
            if (oResultValid) begin
                rv_count++;
                rv_cyc = r;
            end
            tick();
        end
        iStart   = 1'b0;
        iInValid = 1'b0;
        iRstN    = 1'b1;
    endtask

    initial begin
        logic [10:0] pass0_mask;
        logic [10:0] pass1_mask;
        int clear_cyc, rv_cyc, rv_count;

        pass0_mask = 11'b00110110110;
        pass1_mask = 11'b01101101100;

        for (int c = 0; c < 28; c++) begin
            logic run;
            int   s;
            run = (c >= 13 && c <= 23);
            s   = c - 13;
            vecs[c].start   = (c == 0);
            vecs[c].valid   = (c >= 1 && c <= 11);
            vecs[c].in_data = vecs[c].valid ? beat_data(c - 1) : 24'd0;
            vecs[c].in_w    = vecs[c].valid ? beat_w(c - 1) : 8'd0;
            vecs[c].exp_out = {(c >= 1 && c <= 11),
                               (c == 12),
                               run ? {pass1_mask[s], pass0_mask[s]} : 2'b00,
                               run ? beat_data(s) : 24'd0,
                               (run && s < 9) ? beat_w(s) : 8'd0,
                               (c == 26),
                               (c >= 1 && c <= 26)};
        end

        // Reset held three cycles with random inputs.
        iRstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iStart              = 1'($urandom);
            iInValid            = 1'($urandom);
            iCfsOutputLeftShift = 5'($urandom);
            iInData             = 24'($urandom);
            iInWeight           = 8'($urandom);
            iResult             = 24'($urandom);
            tick();
            check_output("reset_outputs", 64'(out_bundle()), 64'd0);
            check_output("reset_result", 64'(oResult), 64'd0);
            check_output("reset_shift", 64'(oCfsOutputLeftShift), 64'd0);
        end
        iRstN               = 1'b1;
        iStart              = 1'b0;
        iInValid            = 1'b0;
        iInData             = '0;
        iInWeight           = '0;
        iCfsOutputLeftShift = 5'd3;
        iResult             = RES_VAL;
        tick();
        tick();

        $display("[TB] nominal window");
        for (int c = 0; c < 28; c++) begin
            apply_stimulus(vecs[c]);
            check_output($sformatf("nominal[%0d]", c), 64'(out_bundle()), 64'(vecs[c].exp_out));
            if (c == 26) check_output("nominal_result", 64'(oResult), 64'(RES_VAL));
            tick();
        end
        check_output("nominal_result_hold", 64'(oResult), 64'(RES_VAL));
        check_output("nominal_shift", 64'(oCfsOutputLeftShift), 64'd3);

        $display("[TB] four-cycle bubble in LOAD");
        run_window(5'd3, 5'd3, 6, 4, -1, -1, clear_cyc, rv_cyc, rv_count);
        check_output("bubble_clear_cycle", 64'(clear_cyc), 64'd16);
        check_output("bubble_rv_cycle", 64'(rv_cyc), 64'd30);
        check_output("bubble_rv_count", 64'(rv_count), 64'd1);
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
        check_output("bubble_perf_stalls", 64'(oPerfStallCycles), 64'd4);
`endif

        $display("[TB] stray start during RUN");
        run_window(5'd3, 5'd3, -10, 0, 18, -1, clear_cyc, rv_cyc, rv_count);
        check_output("stray_clear_cycle", 64'(clear_cyc), 64'd12);
        check_output("stray_rv_cycle", 64'(rv_cyc), 64'd26);
        check_output("stray_rv_count", 64'(rv_count), 64'd1);
        check_output("stray_idle_busy", 64'(oBusy), 64'd0);

        $display("[TB] reset during RUN beat 5");
        run_window(5'd3, 5'd3, -10, 0, -1, 18, clear_cyc, rv_cyc, rv_count);
        check_output("reset_mid_clear_cycle", 64'(clear_cyc), 64'd12);
        check_output("reset_mid_rv_count", 64'(rv_count), 64'd0);
        check_output("reset_mid_idle_busy", 64'(oBusy), 64'd0);

        $display("[TB] shift latch");
        run_window(5'd7, 5'd2, -10, 0, -1, -1, clear_cyc, rv_cyc, rv_count);
        check_output("shift_held", 64'(oCfsOutputLeftShift), 64'd7);
        check_output("shift_window_rv", 64'(rv_count), 64'd1);
        iCfsOutputLeftShift = 5'd2;
        iStart              = 1'b1;
        tick();
        iStart = 1'b0;
        check_output("shift_relatched", 64'(oCfsOutputLeftShift), 64'd2);
        check_output("shift_in_load_ready", 64'(oInReady), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
